// File: rtl/host_bus_arb_pkg.sv
// Shared types and helpers for the host bus arbiter.
// Optional build macro used by the top level: HOST_BUS_ARB_STALL_CNT_EN.
package host_bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Bit width needed to hold an index in [0, n-1], never less than one bit.
  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/host_bus_arbiter_id_fifo.sv
// In-order ID FIFO recording which host owns each outstanding transaction.
// Head entry is read combinationally so responses route in the same cycle.
module arb_id_fifo
  import host_bus_arb_pkg::*;
#(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = clog2_min1(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic [PtrW-1:0]  w_wr_ptr_nxt;
  logic [PtrW-1:0]  w_rd_ptr_nxt;

  assign w_wr_ptr_nxt = (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= w_wr_ptr_nxt;
      if (pop_i)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by the count.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/host_bus_arbiter.sv
// Round-robin arbiter sharing one device port between NrHosts hosts.
// Define HOST_BUS_ARB_STALL_CNT_EN to add per-host stall counters (stall_cnt_o).
module host_bus_arbiter
  import host_bus_arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrHosts-1:0]              host_req_i,
  output logic [NrHosts-1:0]              host_gnt_o,
  input  logic [NrHosts*AddrWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]              host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]              host_rvalid_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic [NrHosts-1:0]              host_err_o,
  output logic                            dev_req_o,
  input  logic                            dev_gnt_i,
  output logic [AddrWidth-1:0]            dev_addr_o,
  output logic                            dev_we_o,
  output logic [DataWidth/8-1:0]          dev_be_o,
  output logic [DataWidth-1:0]            dev_wdata_o,
  input  logic                            dev_rvalid_i,
  input  logic [DataWidth-1:0]            dev_rdata_i,
  input  logic                            dev_err_i,
  output logic                            spurious_o
`ifdef HOST_BUS_ARB_STALL_CNT_EN
  ,
  output logic [NrHosts*16-1:0]           stall_cnt_o
`endif
);

  localparam int IdW = clog2_min1(NrHosts);
  localparam int BeW = DataWidth / 8;

  arb_state_e       r_state, w_state_nxt;
  logic [IdW-1:0]   r_ptr;
  logic [IdW-1:0]   r_hold_sel;
  logic [IdW-1:0]   w_rr_sel;
  logic             w_rr_found;
  logic [IdW-1:0]   w_sel;
  logic             w_dev_req;
  logic             w_push;
  logic             w_pop;
  logic [IdW-1:0]   w_head;
  logic             w_full;
  logic             w_empty;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    for (int k = 0; k < NrHosts; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NrHosts;
      if (!w_rr_found && host_req_i[idx]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = IdW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = w_rr_sel;
    w_dev_req   = 1'b0;
    case (r_state)
      IDLE: begin
        w_dev_req = w_rr_found && !w_full;
        if (w_dev_req && !dev_gnt_i) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_sel     = r_hold_sel;
        w_dev_req = host_req_i[r_hold_sel] && !w_full;
        if (!host_req_i[r_hold_sel] || (w_dev_req && dev_gnt_i)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset must clear every output immediately, not only at the next edge.
    if (rst_i) w_dev_req = 1'b0;
  end

  assign w_push = w_dev_req && dev_gnt_i;
  assign w_pop  = dev_rvalid_i && !w_empty && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_dev_req && !dev_gnt_i) r_hold_sel <= w_sel;
      if (w_push) r_ptr <= (w_sel == IdW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
    end
  end

  arb_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_sel),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign dev_req_o   = w_dev_req;
  assign dev_addr_o  = w_dev_req ? host_addr_i[w_sel*AddrWidth +: AddrWidth] : '0;
  assign dev_we_o    = w_dev_req ? host_we_i[w_sel] : 1'b0;
  assign dev_be_o    = w_dev_req ? host_be_i[w_sel*BeW +: BeW] : '0;
  assign dev_wdata_o = w_dev_req ? host_wdata_i[w_sel*DataWidth +: DataWidth] : '0;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (w_push) host_gnt_o[w_sel] = 1'b1;
    if (w_pop) begin
      host_rvalid_o[w_head] = 1'b1;
      host_err_o[w_head]    = dev_err_i;
    end
  end

  assign host_rdata_o = w_pop ? dev_rdata_i : '0;
  assign spurious_o   = dev_rvalid_i && w_empty && !rst_i;

`ifdef HOST_BUS_ARB_STALL_CNT_EN
  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_stall
    logic [15:0] r_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (host_req_i[gi] && !host_gnt_o[gi] && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stall_cnt_o[gi*16 +: 16] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Directed self-checking bench for host_bus_arbiter (NrHosts=2, depth 4).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_host_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [63:0] host_addr_i;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic        dev_req_o;
  logic        dev_gnt_i;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        dev_err_i;
  logic        spurious_o;
`ifdef HOST_BUS_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  host_bus_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .dev_req_o     (dev_req_o),
    .dev_gnt_i     (dev_gnt_i),
    .dev_addr_o    (dev_addr_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_wdata_o   (dev_wdata_o),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rdata_i   (dev_rdata_i),
    .dev_err_i     (dev_err_i),
    .spurious_o    (spurious_o)
`ifdef HOST_BUS_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic err, input logic [31:0] rdata);
    host_req_i   = req;
    dev_gnt_i    = gnt;
    dev_rvalid_i = rv;
    dev_err_i    = err;
    dev_rdata_i  = rdata;
    #1;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  // Round-robin table: after the single-host test the pointer is at host1.
  logic [1:0] rr_req [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
  logic       rr_rv  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] rr_gnt [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
  logic [1:0] rr_rvo [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [31:0] rr_adr[5] = '{32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h0};

  initial begin
    rst_i        = 1'b1;
    host_addr_i  = {32'h0000_2000, 32'h0010_0000};
    host_we_i    = 2'b00;
    host_be_i    = 8'hFF;
    host_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_dev_req", dev_req_o, 0);
    chk("reset_gnt", host_gnt_o, 0);
    chk("reset_rvalid", host_rvalid_o, 0);
    chk("reset_rdata", host_rdata_o, 0);
    adv();
    adv();
    rst_i = 1'b0;

    // Single host read
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("single_gnt", host_gnt_o, 2'b01);
    chk("single_dev_req", dev_req_o, 1);
    chk("single_addr", dev_addr_o, 32'h0010_0000);
    adv();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("single_rvalid", host_rvalid_o, 2'b01);
    chk("single_rdata", host_rdata_o, 32'hDEAD_BEEF);
    chk("single_err", host_err_o, 2'b00);
    adv();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    chk("idle_rdata_zero", host_rdata_o, 0);

    // Round-robin with overlapping responses
    host_addr_i = {32'h0000_2000, 32'h0000_1000};
    for (int c = 0; c < 5; c++) begin
      drive(rr_req[c], 1'b1, rr_rv[c], 1'b0, 32'h100 + c);
      chk($sformatf("rr_gnt_c%0d", c), host_gnt_o, rr_gnt[c]);
      chk($sformatf("rr_addr_c%0d", c), dev_addr_o, rr_adr[c]);
      chk($sformatf("rr_rvalid_c%0d", c), host_rvalid_o, rr_rvo[c]);
      adv();
    end

    // Hold: host1 selected (pointer at host1), device stalls 3 cycles
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("hold_addr_c%0d", c), dev_addr_o, 32'h2000);
      chk($sformatf("hold_gnt_c%0d", c), host_gnt_o, 2'b00);
      adv();
    end
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold_release_gnt", host_gnt_o, 2'b10);
    adv();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold_next_gnt", host_gnt_o, 2'b01);
    chk("hold_next_addr", dev_addr_o, 32'h1000);
    adv();

    // Error response returns to host1, then clean response to host0
    drive(2'b00, 1'b0, 1'b1, 1'b1, 32'hE000_0001);
    chk("err_rvalid", host_rvalid_o, 2'b10);
    chk("err_err", host_err_o, 2'b10);
    adv();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0002);
    chk("err_next_rvalid", host_rvalid_o, 2'b01);
    chk("err_next_err", host_err_o, 2'b00);
    adv();

    // Full: four grants with no responses, fifth request blocked
    for (int c = 0; c < 4; c++) begin
      drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("fill_gnt_c%0d", c), host_gnt_o, 2'b01);
      adv();
    end
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_dev_req", dev_req_o, 0);
    chk("full_gnt", host_gnt_o, 2'b00);
    adv();
    drive(2'b01, 1'b1, 1'b1, 1'b0, 32'h55);
    chk("full_pop_dev_req", dev_req_o, 0);
    chk("full_pop_rvalid", host_rvalid_o, 2'b01);
    adv();
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("unfull_gnt", host_gnt_o, 2'b01);
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h60 + c);
      chk($sformatf("drain_rvalid_c%0d", c), host_rvalid_o, 2'b01);
      adv();
    end

    // Reset with 2 outstanding, asserted mid-cycle
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_gnt", host_gnt_o, 2'b10);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_dev_req", dev_req_o, 0);
    chk("rst_async_gnt", host_gnt_o, 2'b00);
    adv();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
    adv();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hBAD0_0000);
    chk("spurious_pulse", spurious_o, 1);
    chk("spurious_rvalid", host_rvalid_o, 2'b00);
    chk("spurious_rdata", host_rdata_o, 0);
    adv();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_rst_spurious", spurious_o, 0);
    chk("post_rst_gnt", host_gnt_o, 2'b01);
    adv();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
